// File: rtl/cache_refill.sv
// Instruction-cache line refill: fetches one line word-by-word starting at the
// missed word, wrapping within the line, then strobes the packed line to the store port.
module cache_refill #(
    parameter int N_CACHELINE_LENGTH = 4,
    parameter int BITSIZE            = 32,
    localparam int OFFW              = $clog2(N_CACHELINE_LENGTH)
) (
    input  logic                                  clk,
    input  logic                                  rstn_i,
    input  logic                                  miss_i,
    input  logic [BITSIZE-1:0]                    miss_addr_i,
    input  logic                                  flush_i,
    output logic                                  busy_o,
    output logic                                  mem_req_o,
    output logic [BITSIZE-1:0]                    mem_addr_o,
    input  logic                                  mem_valid_i,
    input  logic [BITSIZE-1:0]                    mem_data_i,
    output logic                                  store_o,
    output logic [BITSIZE-1:0]                    line_addr_o,
    output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_STORE} state_t;

    localparam int unsigned    LAST_I   = N_CACHELINE_LENGTH - 1;
    localparam logic [OFFW:0]  LAST_CNT = LAST_I[OFFW:0];

    state_t                                           r_state;
    state_t                                           w_next;
    logic [BITSIZE-OFFW-1:0]                          r_base;
    logic [OFFW-1:0]                                  r_off;
    logic [OFFW:0]                                    r_cnt;
    logic [N_CACHELINE_LENGTH-1:0][BITSIZE-1:0]       r_line;
    logic                                             w_accept;
    logic                                             w_beat;

    assign w_accept = (r_state == S_IDLE) && miss_i;
    // A flushed beat is discarded so an aborted line never partially commits.
    assign w_beat   = (r_state == S_REQ) && mem_valid_i && !flush_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (miss_i) w_next = S_REQ;
            S_REQ: begin
                if (flush_i)                             w_next = S_IDLE;
                else if (w_beat && (r_cnt == LAST_CNT))  w_next = S_STORE;
            end
            S_STORE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_base <= miss_addr_i[BITSIZE-1:OFFW];
                r_off  <= miss_addr_i[OFFW-1:0];
                r_cnt  <= '0;
            end else if (w_beat) begin
                r_line[r_off] <= mem_data_i;
                r_off         <= r_off + 1'b1;
                r_cnt         <= r_cnt + 1'b1;
            end
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign mem_req_o   = (r_state == S_REQ);
    assign store_o     = (r_state == S_STORE);
    assign mem_addr_o  = {r_base, r_off};
    assign line_addr_o = {r_base, {OFFW{1'b0}}};
    assign line_data_o = r_line;

endmodule
